ddr_lane_sched: RTL and testbench
=================================

// Module: ddr_lane_sched
// PURPOSE
//  Round-robin scheduler feeding one shared double-edge output lane from N_REQ requesters.
//  Grants one requester at a time and latches its WORD_W-bit word.
//  Streams the word out as 2 bits per clk (rise bit, fall bit) to the double-edge flop stage.
//  Sits between packet sources and the DDR flop/mux that selects rise/fall by clk phase.
// PARAMETERS
//  N_REQ   4  number of requesters (>=2)
//  WORD_W  8  bits per word; must be even, >=4
// PORTS
//  clk        in   1              system clock, all state on posedge
//  rst        in   1              asynchronous, active-high reset
//  req_valid  in   N_REQ          requester i has a word pending
//  req_data   in   N_REQ*WORD_W   word of requester i at [i*WORD_W +: WORD_W]
//  req_ready  out  N_REQ          one-hot accept strobe; transfer = valid & ready
//  lane_rise  out  1              bit for the rising-edge half of the current beat
//  lane_fall  out  1              bit for the falling-edge half of the current beat
//  lane_en    out  1              1 while lane_rise/lane_fall carry word bits
//  lane_src   out  clog2(N_REQ)   index of the requester whose word is on the lane
//  busy       out  1              1 in SHIFT state
// BEHAVIOUR
//  Reset: state=IDLE, lane_rise=0, lane_fall=0, lane_en=0, lane_src=0, busy=0.
//   last_grant=N_REQ-1, so the first priority goes to req 0.
//  Reset is asynchronous: asserting it mid-word aborts the word immediately.
//   No resume after reset; the aborted requester must re-request.
//  States:
//   IDLE: ready may assert only here or on the last beat.
//   SHIFT: beat counter 0..WORD_W/2-1.
//  Grant: among asserted req_valid, pick the first index after last_grant, wrapping N_REQ-1 -> 0.
//   req_ready is combinational and one-hot (zero if no valid) in the accept cycle.
//   last_grant updates on accept.
//  Accept cycle c (IDLE): shift reg <= word; lane_src <= g; state -> SHIFT.
//   First beat is visible in cycle c+1.
//  SHIFT beat k: lane_rise = word[WORD_W-1-2k]; lane_fall = word[WORD_W-2-2k].
//   Output is MSB first; lane_en=1.
//  Last beat (k=WORD_W/2-1):
//   If any req_valid, grant and accept in the same cycle (back-to-back, no bubble).
//   Otherwise go to IDLE: lane_en=0, lane_rise/lane_fall=0 next cycle.
//  Word throughput is WORD_W/2 cycles. There is no idle gap between back-to-back words.
//  Valid asserted during SHIFT (not last beat) waits; ready stays 0.
//   Requesters hold valid and data until ready.
//  Single requester continuously valid: served back-to-back.
//  All valid: grants rotate 0,1,2,...,N_REQ-1,0.
//  All lane outputs are registered. req_ready is the only combinational output.
// STRUCTURE
//  Package ddr_lane_pkg:
//   state encoding (IDLE, SHIFT)
//   SRC_W = clog2(N_REQ)
//   BEATS = WORD_W/2
//  Sub-module rr_arbiter (N_REQ): inputs req and last_grant; outputs one-hot gnt and gnt_idx.
//   It is purely combinational.
//  Top level holds the FSM, beat counter, shift register and last_grant register.
// TESTING
//  1. Reset, no valid -> req_ready=0, lane_en=0, lane_rise=lane_fall=0, busy=0
//     for 20 cycles.
//  2. WORD_W=8, req1 valid data 8'hB4 -> ready[1] one cycle; next 4 cycles
//     (rise,fall) = (1,0),(1,1),(0,1),(0,0); lane_src=1; then lane_en=0.
//  3. All 4 valid continuously -> grant order 0,1,2,3,0.
//     lane_en stays 1 with no gap; each word lasts 4 cycles.
//  4. req2 valid during beat 1 of req0's word -> ready[2] on beat 3 only;
//     req2's first beat immediately follows req0's last beat.
//  5. Assert rst at beat 2 of word 8'hFF -> lane_en=0, lane_rise=0 asynchronously.
//     After release, state is IDLE and the next grant starts at req 0.
//  6. Only req3 valid, repeated 3 words -> three back-to-back accepts; lane_src=3 throughout.

Source files
------------

// File: rtl/ddr_lane_pkg.sv
// Shared types and sizing helpers for the DDR lane scheduler.
package ddr_lane_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_WORD_W = 8;
    localparam int SRC_W      = $clog2(DEF_N_REQ);
    localparam int BEATS      = DEF_WORD_W / 2;

    // Two bits leave the lane per clock, so a word takes half its width in beats.
    function automatic int beats_of(input int word_w);
        return word_w / 2;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from the slot after last_grant.
module rr_arbiter
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last_grant,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_idx
);
    localparam int IDX_W = $clog2(N_REQ);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (req[IDX_W'((int'(last_grant) + i) % N_REQ)] && gnt == '0) begin
                gnt[IDX_W'((int'(last_grant) + i) % N_REQ)] = 1'b1;
                gnt_idx = IDX_W'((int'(last_grant) + i) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/ddr_lane_sched.sv
// Round-robin scheduler that serialises one requester word at a time onto a
// two-bit-per-clock (rise/fall) lane, MSB first, with back-to-back words.
module ddr_lane_sched
    import ddr_lane_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*WORD_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      lane_rise,
    output logic                      lane_fall,
    output logic                      lane_en,
    output logic [$clog2(N_REQ)-1:0]  lane_src,
    output logic                      busy
);
    localparam int SRC_BITS = $clog2(N_REQ);
    localparam int BEAT_N   = beats_of(WORD_W);
    localparam int CNT_W    = $clog2(BEAT_N);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEAT_N - 1);

    state_t              state;
    logic [CNT_W-1:0]    beat;
    logic [WORD_W-1:0]   shift_q;
    logic [SRC_BITS-1:0] last_grant;
    logic [N_REQ-1:0]    gnt;
    logic [SRC_BITS-1:0] gnt_idx;
    logic [WORD_W-1:0]   gnt_word;
    logic                accept_window;
    logic                accept;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx)
    );

    // Accepting on the last beat is what removes the bubble between words.
    assign accept_window = (state == IDLE) || (state == SHIFT && beat == LAST_BEAT);
    assign accept        = accept_window && (|req_valid) && !rst;
    assign req_ready     = accept ? gnt : '0;
    assign gnt_word      = req_data[gnt_idx*WORD_W +: WORD_W];

    // The lane bits come straight from flops; shift_q holds the beats not yet shown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            beat       <= '0;
            shift_q    <= '0;
            last_grant <= SRC_BITS'(N_REQ - 1);
            lane_rise  <= 1'b0;
            lane_fall  <= 1'b0;
            lane_en    <= 1'b0;
            lane_src   <= '0;
            busy       <= 1'b0;
        end else if (accept) begin
            state      <= SHIFT;
            busy       <= 1'b1;
            beat       <= '0;
            shift_q    <= gnt_word << 2;
            lane_rise  <= gnt_word[WORD_W-1];
            lane_fall  <= gnt_word[WORD_W-2];
            lane_en    <= 1'b1;
            lane_src   <= gnt_idx;
            last_grant <= gnt_idx;
        end else if (state == SHIFT) begin
            if (beat == LAST_BEAT) begin
                state     <= IDLE;
                busy      <= 1'b0;
                beat      <= '0;
                lane_en   <= 1'b0;
                lane_rise <= 1'b0;
                lane_fall <= 1'b0;
            end else begin
                beat      <= beat + 1'b1;
                lane_rise <= shift_q[WORD_W-1];
                lane_fall <= shift_q[WORD_W-2];
                shift_q   <= shift_q << 2;
            end
        end
    end

endmodule

// File: tb/tb_ddr_lane_sched.sv
// Self-checking bench for ddr_lane_sched: queue-based lane model plus directed literal checks.
module tb_ddr_lane_sched;
    import ddr_lane_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int NB = W / 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data  = '0;
    logic [N-1:0]   req_ready;
    logic           lane_rise, lane_fall, lane_en, busy;
    logic [1:0]     lane_src;

    ddr_lane_sched #(.N_REQ(N), .WORD_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .lane_rise (lane_rise),
        .lane_fall (lane_fall),
        .lane_en   (lane_en),
        .lane_src  (lane_src),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    endtask

    // Per-requester pending words; each requester holds its head word until accepted.
    logic [W-1:0] pend [N][$];
    logic [N-1:0] acc_q = '0;

    task automatic applyStimulus(input int idx, input logic [W-1:0] word);
        pend[idx].push_back(word);
    endtask

    always @(negedge clk) acc_q = rst ? '0 : (req_ready & req_valid);

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++)
            if (acc_q[i] && pend[i].size() > 0) void'(pend[i].pop_front());
        for (int i = 0; i < N; i++) begin
            req_valid[i]     = pend[i].size() > 0;
            req_data[i*W +: W] = (pend[i].size() > 0) ? pend[i][0] : '0;
        end
    end

    // Model: the lane is a queue of beats still to be shown; grants may only happen
    // when at most one beat (the one on the lane now) remains.
    typedef struct packed {
        logic       r;
        logic       f;
        logic [1:0] src;
    } beat_t;

    beat_t        mq[$];
    beat_t        m_cur;
    int           m_lg  = N - 1;
    int           m_src = 0;
    int           m_g;
    logic [N-1:0] exp_ready;
    logic [W-1:0] m_word;

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            m_lg  = N - 1;
            m_src = 0;
        end
        m_cur = (mq.size() > 0) ? mq[0] : '0;
        checkOutput("m_lane_en",   lane_en,   mq.size() > 0);
        checkOutput("m_lane_rise", lane_rise, m_cur.r);
        checkOutput("m_lane_fall", lane_fall, m_cur.f);
        checkOutput("m_busy",      busy,      mq.size() > 0);
        checkOutput("m_lane_src",  lane_src,  m_src);
        exp_ready = '0;
        m_g = -1;
        if (!rst && mq.size() <= 1)
            for (int k = 1; k <= N; k++)
                if (m_g < 0 && req_valid[(m_lg + k) % N]) m_g = (m_lg + k) % N;
        if (m_g >= 0) exp_ready[m_g] = 1'b1;
        checkOutput("m_req_ready", req_ready, exp_ready);
        if (!rst) begin
            if (mq.size() > 0) void'(mq.pop_front());
            if (m_g >= 0) begin
                m_word = req_data[m_g*W +: W];
                for (int k = 0; k < NB; k++)
                    mq.push_back({m_word[W-1-2*k], m_word[W-2-2*k], 2'(m_g)});
                m_lg  = m_g;
                m_src = m_g;
            end
        end
    end

    task automatic waitGrant(input logic [N-1:0] expected, input string name);
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (req_ready != '0) break;
        end
        checkOutput(name, req_ready, expected);
    endtask

    task automatic doReset();
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    logic [1:0] t2_pairs [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    int         t3_order [5] = '{0, 1, 2, 3, 0};
    int         t6_acc;
    int         t6_en;

    initial begin
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // Quiet after reset
        repeat (20) begin
            @(negedge clk);
            checkOutput("t1_ready", req_ready, '0);
            checkOutput("t1_lane", {lane_en, lane_rise, lane_fall, busy}, '0);
        end

        // Single word 0xB4 from req1
        applyStimulus(1, 8'hB4);
        waitGrant(4'b0010, "t2_grant");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("t2_beat", {lane_en, lane_rise, lane_fall}, {1'b1, t2_pairs[k]});
            checkOutput("t2_src", lane_src, 1);
        end
        @(negedge clk);
        checkOutput("t2_end", lane_en, 0);

        // All requesters valid: rotation from a fresh reset
        doReset();
        applyStimulus(0, 8'h01);
        applyStimulus(0, 8'h05);
        applyStimulus(1, 8'h02);
        applyStimulus(2, 8'h03);
        applyStimulus(3, 8'h04);
        for (int j = 0; j < 5; j++)
            waitGrant(4'(1 << t3_order[j]), "t3_order");
        repeat (8) @(negedge clk);

        // Late arrival waits for the last beat
        applyStimulus(0, 8'h5A);
        waitGrant(4'b0001, "t4_grant0");
        @(negedge clk);
        applyStimulus(2, 8'hC3);
        @(negedge clk);
        checkOutput("t4_wait_b1", req_ready, '0);
        @(negedge clk);
        checkOutput("t4_wait_b2", req_ready, '0);
        @(negedge clk);
        checkOutput("t4_ready_b3", req_ready, 4'b0100);
        @(negedge clk);
        checkOutput("t4_next_src", {lane_en, lane_src}, {1'b1, 2'd2});
        repeat (8) @(negedge clk);

        // Asynchronous abort mid-word
        applyStimulus(0, 8'hFF);
        waitGrant(4'b0001, "t5_grant");
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("t5_abort", {lane_en, lane_rise, lane_fall, busy}, '0);
        @(negedge clk);
        #1 rst = 1'b0;
        applyStimulus(0, 8'h81);
        applyStimulus(2, 8'h42);
        waitGrant(4'b0001, "t5_first_after_rst");
        repeat (12) @(negedge clk);

        // Single requester streaming three words
        applyStimulus(3, 8'h11);
        applyStimulus(3, 8'h22);
        applyStimulus(3, 8'h33);
        t6_acc = 0;
        t6_en  = 0;
        repeat (20) begin
            @(negedge clk);
            if (req_ready != '0) begin
                t6_acc++;
                checkOutput("t6_ready", req_ready, 4'b1000);
            end
            if (lane_en) begin
                t6_en++;
                checkOutput("t6_src", lane_src, 3);
            end
        end
        checkOutput("t6_accepts", t6_acc, 3);
        checkOutput("t6_en_cycles", t6_en, 12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
